ret_recovery_ctrl: RTL and testbench
====================================

Name: ret_recovery_ctrl

Overview:
Sequencer for return-stack recovery after a fetch mispredict. It owns the recovery FSM: it walks the return recovery queue from its top and issues one restore per cycle, then optionally performs one post-recovery save that writes a decode-detected return address. It stalls fetch while active. The return stack and recovery queue storage live outside this block; it only drives their control strobes.

Parameters:
RQSIZE, 8, recovery queue depth (power of two, ≥2)
IDX_W, 3, return stack index width
FID_W, 4, fetch ID width; IDs wrap modulo 2^FID_W
OFF_W, 3, fetch offset width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
IN_misprValid  in  1  mispredict this cycle
IN_misprFetchID  in  FID_W  fetch ID of the mispredicting branch
IN_misprOffs  in  OFF_W  offset of the mispredicting branch
IN_misprIsFetchBranch  in  1  mispredict is the fetch-time branch itself
IN_retUpdValid  in  1  decode detected a late return
IN_retUpdIdx  in  IDX_W  stack index reported by decode
IN_retUpdAddr  in  31  return address reported by decode (halfword units)
IN_comFetchID  in  FID_W  oldest uncommitted fetch ID (comparison base)
IN_qEmpty  in  1  recovery queue empty
IN_qFull  in  1  recovery queue full
IN_qTopFetchID  in  FID_W  fetchID of queue entry at top (index qindex-1)
IN_qTopOffs  in  OFF_W  offs of queue top entry
OUT_popTop  out  1  restore top entry into stack, decrement queue top pointer
OUT_saveWr  out  1  push save entry into queue and write stack
OUT_saveIdx  out  IDX_W  stack index for save
OUT_saveAddr  out  31  address for save
OUT_saveFetchID  out  FID_W  fetchID tag for save
OUT_saveOffs  out  OFF_W  offs tag for save
OUT_forwardIdx  out  1  registered pulse, cycle after mispredict: stack index takes recovery index
OUT_stall  out  1  fetch stall
OUT_busy  out  1  state != IDLE

Behaviour:
- States: IDLE, WALK, SAVE. Reset: state IDLE; all outputs 0; save registers X. Reset mid-WALK/SAVE aborts with no strobe that cycle.
- On IN_misprValid (any state, highest priority): latch recID=misprFetchID, recBase=comFetchID, recOffs=misprOffs, overwOwn=isFetchBranch && !retUpdValid.
- doSave=isFetchBranch && retUpdValid. If doSave, latch savePending=1, saveIdx=retUpdIdx+1 (mod 2^IDX_W), saveAddr=retUpdAddr+1 (mod 2^31), saveFetchID=misprFetchID, saveOffs=misprOffs; else savePending=0.
- Next state WALK if !qEmpty || doSave, else IDLE. OUT_forwardIdx=1 next cycle. No popTop/saveWr in the mispredict cycle. A mispredict during WALK/SAVE discards any older pending save.
- Relative compare: qRel=(qTopFetchID−recBase), rRel=(recID−recBase), both mod 2^FID_W. cont = !qEmpty && (qRel>rRel || (qRel==rRel && (overwOwn ? qTopOffs>=recOffs : qTopOffs>recOffs))).
- WALK: if cont, OUT_popTop=1 (combinational), stay. Else, if savePending, go SAVE; else go IDLE.
- SAVE: one cycle. OUT_saveWr=!IN_qFull. Save outputs valid; clear savePending; go IDLE. If the queue is full, the save is dropped silently.
- OUT_stall = (WALK && (cont || savePending)) || SAVE. Stall is low in the WALK exit cycle when no save is pending.
- Latency, N restorable entries with save: pops in cycles 1..N, exit at N+1, SAVE at N+2, IDLE at N+3. Without save: IDLE at N+2.

Optional Feature:
RET_REC_WATCHDOG_EN: adds port OUT_wdError (1 bit) and a counter of consecutive WALK cycles. When the count exceeds RQSIZE+1, OUT_wdError is set sticky until rst, and the block forces IDLE. Without the macro, there is no port and no counter, and WALK is unbounded.

Decomposition:
- Shared package: RetRecState_t enum; fetch ID, offset and stack index typedefs; relative-compare function fid_rel_gt(a, b, base).
- Sub-module ret_rec_cmp: the combinational cont comparator, so verification can test it standalone.

Test Plan:
- Reset, then misprValid with qEmpty=1 and isFetchBranch=0 -> stays IDLE; forwardIdx pulse next cycle; stall never high.
- recBase=0, recID=3, recOffs=2, queue tops fetchID 5, 4, 3 (offs 3) then 3 (offs 1) -> popTop for 3 cycles, exit on the 4th, IDLE, stall high for exactly 3 cycles.
- Wrap: recBase=14, recID=15, top fetchID=1 -> qRel=3 > rRel=1 -> pop; top=15 with offs equal, overwOwn=1 -> pop; overwOwn=0 -> stop.
- doSave: retUpdIdx=7, retUpdAddr=0x7FFFFFFF, qEmpty=1 -> WALK, then SAVE with saveIdx=0, saveAddr=0, saveWr=1; with IN_qFull=1, saveWr=0.
- Second mispredict mid-WALK after 1 pop -> no pop that cycle; new recID latched; old savePending cleared; walk restarts.
- Watchdog (RET_REC_WATCHDOG_EN): hold cont true for RQSIZE+2 cycles -> OUT_wdError=1 sticky, state IDLE.

Source files
------------

// File: rtl/ret_recovery_ctrl_pkg.sv
// Shared types and helpers for the return-stack recovery sequencer.
// The widths here are the ones the top module is built with.
package ret_recovery_ctrl_pkg;

    localparam int FID_W_P = 4;
    localparam int OFF_W_P = 3;
    localparam int IDX_W_P = 3;

    typedef logic [FID_W_P-1:0] fid_t;
    typedef logic [OFF_W_P-1:0] off_t;
    typedef logic [IDX_W_P-1:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_SAVE = 2'd2
    } RetRecState_t;

    // Fetch IDs wrap, so age is judged by distance from a common base ID.
    function automatic logic fid_rel_gt(input fid_t a, input fid_t b, input fid_t base);
        fid_t a_rel;
        fid_t b_rel;
        a_rel = a - base;
        b_rel = b - base;
        return a_rel > b_rel;
    endfunction

endpackage

// File: rtl/ret_rec_cmp.sv
// Continue-walk comparator: is the recovery queue top younger than the
// mispredicting branch, relative to the recovery base fetch ID?
module ret_rec_cmp
    import ret_recovery_ctrl_pkg::*;
(
    input  logic q_empty,
    input  fid_t q_top_fid,
    input  off_t q_top_offs,
    input  fid_t rec_id,
    input  fid_t rec_base,
    input  off_t rec_offs,
    input  logic overw_own,
    output logic cont
);

    logic same_s;
    logic offs_ok_s;

    // Same fetch block: the offset decides; the branch's own entry counts when it overwrote it.
    always_comb begin
        same_s    = (q_top_fid == rec_id);
        offs_ok_s = overw_own ? (q_top_offs >= rec_offs) : (q_top_offs > rec_offs);
        cont      = !q_empty && (fid_rel_gt(q_top_fid, rec_id, rec_base) || (same_s && offs_ok_s));
    end

endmodule

// File: rtl/ret_recovery_ctrl.sv
// Return-stack recovery sequencer: after a mispredict it pops the recovery queue
// one entry per cycle, then optionally performs one save. Watchdog: RET_REC_WATCHDOG_EN.
module ret_recovery_ctrl
    import ret_recovery_ctrl_pkg::*;
#(
    parameter int RQSIZE = 8,
    parameter int IDX_W  = IDX_W_P,
    parameter int FID_W  = FID_W_P,
    parameter int OFF_W  = OFF_W_P
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_misprValid,
    input  logic [FID_W-1:0] IN_misprFetchID,
    input  logic [OFF_W-1:0] IN_misprOffs,
    input  logic             IN_misprIsFetchBranch,
    input  logic             IN_retUpdValid,
    input  logic [IDX_W-1:0] IN_retUpdIdx,
    input  logic [30:0]      IN_retUpdAddr,
    input  logic [FID_W-1:0] IN_comFetchID,
    input  logic             IN_qEmpty,
    input  logic             IN_qFull,
    input  logic [FID_W-1:0] IN_qTopFetchID,
    input  logic [OFF_W-1:0] IN_qTopOffs,
    output logic             OUT_popTop,
    output logic             OUT_saveWr,
    output logic [IDX_W-1:0] OUT_saveIdx,
    output logic [30:0]      OUT_saveAddr,
    output logic [FID_W-1:0] OUT_saveFetchID,
    output logic [OFF_W-1:0] OUT_saveOffs,
    output logic             OUT_forwardIdx,
    output logic             OUT_stall,
    output logic             OUT_busy
`ifdef RET_REC_WATCHDOG_EN
    ,
    output logic             OUT_wdError
`endif
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_WALK = ST_WALK;
    localparam logic [1:0] S_SAVE = ST_SAVE;

    if (FID_W != FID_W_P || OFF_W != OFF_W_P || IDX_W != IDX_W_P || RQSIZE < 2) begin : g_cfg_check
        $error("ret_recovery_ctrl: parameters must match ret_recovery_ctrl_pkg widths");
    end

    logic [1:0]       state_q, state_d;
    logic [FID_W-1:0] rec_id_q, rec_id_d;
    logic [FID_W-1:0] rec_base_q, rec_base_d;
    logic [OFF_W-1:0] rec_offs_q, rec_offs_d;
    logic             overw_own_q, overw_own_d;
    logic             save_pending_q, save_pending_d;
    logic             fwd_q, fwd_d;
    logic [IDX_W-1:0] save_idx_q, save_idx_d;
    logic [30:0]      save_addr_q, save_addr_d;
    logic [FID_W-1:0] save_fid_q, save_fid_d;
    logic [OFF_W-1:0] save_offs_q, save_offs_d;
    logic             cont_s;
    logic             do_save_s;
    logic             wd_trip_s;

    assign do_save_s = IN_misprIsFetchBranch && IN_retUpdValid;

    ret_rec_cmp u_cmp (
        .q_empty    (IN_qEmpty),
        .q_top_fid  (IN_qTopFetchID),
        .q_top_offs (IN_qTopOffs),
        .rec_id     (rec_id_q),
        .rec_base   (rec_base_q),
        .rec_offs   (rec_offs_q),
        .overw_own  (overw_own_q),
        .cont       (cont_s)
    );

    // Next-state: a mispredict always wins and restarts recovery from its own context.
    always_comb begin
        state_d        = state_q;
        rec_id_d       = rec_id_q;
        rec_base_d     = rec_base_q;
        rec_offs_d     = rec_offs_q;
        overw_own_d    = overw_own_q;
        save_pending_d = save_pending_q;
        save_idx_d     = save_idx_q;
        save_addr_d    = save_addr_q;
        save_fid_d     = save_fid_q;
        save_offs_d    = save_offs_q;
        fwd_d          = IN_misprValid;
        if (IN_misprValid) begin
            rec_id_d       = IN_misprFetchID;
            rec_base_d     = IN_comFetchID;
            rec_offs_d     = IN_misprOffs;
            overw_own_d    = IN_misprIsFetchBranch && !IN_retUpdValid;
            save_pending_d = do_save_s;
            if (do_save_s) begin
                save_idx_d  = IN_retUpdIdx + IDX_W'(1);
                save_addr_d = IN_retUpdAddr + 31'd1;
                save_fid_d  = IN_misprFetchID;
                save_offs_d = IN_misprOffs;
            end else begin
                save_idx_d  = save_idx_q;
                save_addr_d = save_addr_q;
                save_fid_d  = save_fid_q;
                save_offs_d = save_offs_q;
            end
            state_d = (!IN_qEmpty || do_save_s) ? S_WALK : S_IDLE;
        end else begin
            case (state_q)
                S_WALK: begin
                    if (wd_trip_s) begin
                        state_d        = S_IDLE;
                        save_pending_d = 1'b0;
                    end else if (cont_s) begin
                        state_d = S_WALK;
                    end else if (save_pending_q) begin
                        state_d = S_SAVE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_SAVE: begin
                    state_d        = S_IDLE;
                    save_pending_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rec_id_q       <= '0;
            rec_base_q     <= '0;
            rec_offs_q     <= '0;
            overw_own_q    <= 1'b0;
            save_pending_q <= 1'b0;
            fwd_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            rec_id_q       <= rec_id_d;
            rec_base_q     <= rec_base_d;
            rec_offs_q     <= rec_offs_d;
            overw_own_q    <= overw_own_d;
            save_pending_q <= save_pending_d;
            fwd_q          <= fwd_d;
        end
    end

    // Save payload needs no reset: it is only observed while in SAVE.
    always_ff @(posedge clk) begin
        save_idx_q  <= save_idx_d;
        save_addr_q <= save_addr_d;
        save_fid_q  <= save_fid_d;
        save_offs_q <= save_offs_d;
    end

`ifdef RET_REC_WATCHDOG_EN
    localparam int              WD_W     = $clog2(RQSIZE + 3);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(RQSIZE + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_err_q, wd_err_d;

    // Counts consecutive WALK cycles; a legal walk never outlasts the queue depth plus exit.
    always_comb begin
        wd_trip_s = (state_q == S_WALK) && (wd_cnt_q == WD_LIMIT) && !IN_misprValid;
        if (IN_misprValid || (state_q != S_WALK)) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
        wd_err_d = wd_err_q || wd_trip_s;
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign OUT_wdError = wd_err_q;
`else
    assign wd_trip_s = 1'b0;
`endif

    // Strobes are suppressed while reset is asserted and in a mispredict cycle.
    always_comb begin
        OUT_popTop     = !rst && !IN_misprValid && (state_q == S_WALK) && cont_s && !wd_trip_s;
        OUT_saveWr     = !rst && !IN_misprValid && (state_q == S_SAVE) && !IN_qFull;
        OUT_stall      = !rst && (((state_q == S_WALK) && (cont_s || save_pending_q))
                                  || (state_q == S_SAVE));
        OUT_busy       = !rst && (state_q != S_IDLE);
        OUT_forwardIdx = !rst && fwd_q;
        if (!rst && (state_q == S_SAVE)) begin
            OUT_saveIdx     = save_idx_q;
            OUT_saveAddr    = save_addr_q;
            OUT_saveFetchID = save_fid_q;
            OUT_saveOffs    = save_offs_q;
        end else begin
            OUT_saveIdx     = '0;
            OUT_saveAddr    = '0;
            OUT_saveFetchID = '0;
            OUT_saveOffs    = '0;
        end
    end

endmodule

// File: tb/tb_ret_recovery_ctrl.sv
// Bench for ret_recovery_ctrl: each driven cycle queues its hand-derived expected
// outputs, which a falling-edge monitor pops and compares.
module tb_ret_recovery_ctrl;

    localparam int RQSIZE = 8;

    localparam logic [4:0] F_NONE      = 5'b00000;  // {pop, saveWr, stall, busy, fwd}
    localparam logic [4:0] F_FWD       = 5'b00001;
    localparam logic [4:0] F_POP_FWD   = 5'b10111;
    localparam logic [4:0] F_POP       = 5'b10110;
    localparam logic [4:0] F_EXIT      = 5'b00010;
    localparam logic [4:0] F_EXIT_FWD  = 5'b00011;
    localparam logic [4:0] F_HOLD      = 5'b00110;
    localparam logic [4:0] F_HOLD_FWD  = 5'b00111;
    localparam logic [4:0] F_SAVE_WR   = 5'b01110;

    logic        clk = 1'b0;
    logic        rst;
    logic        mispr_valid, mispr_is_fb, ret_upd_valid, q_empty, q_full;
    logic [3:0]  mispr_fid, com_fid, q_top_fid;
    logic [2:0]  mispr_offs, ret_upd_idx, q_top_offs;
    logic [30:0] ret_upd_addr;
    logic        pop, save_wr, fwd, stall, busy, wd_err;
    logic [2:0]  save_idx, save_offs;
    logic [30:0] save_addr;
    logic [3:0]  save_fid;

    typedef struct packed {
        logic [4:0]  flags;
        logic        wd;
        logic        has_save;
        logic [2:0]  idx;
        logic [30:0] addr;
        logic [3:0]  fid;
        logic [2:0]  offs;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    ret_recovery_ctrl #(.RQSIZE(RQSIZE)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .IN_misprValid         (mispr_valid),
        .IN_misprFetchID       (mispr_fid),
        .IN_misprOffs          (mispr_offs),
        .IN_misprIsFetchBranch (mispr_is_fb),
        .IN_retUpdValid        (ret_upd_valid),
        .IN_retUpdIdx          (ret_upd_idx),
        .IN_retUpdAddr         (ret_upd_addr),
        .IN_comFetchID         (com_fid),
        .IN_qEmpty             (q_empty),
        .IN_qFull              (q_full),
        .IN_qTopFetchID        (q_top_fid),
        .IN_qTopOffs           (q_top_offs),
        .OUT_popTop            (pop),
        .OUT_saveWr            (save_wr),
        .OUT_saveIdx           (save_idx),
        .OUT_saveAddr          (save_addr),
        .OUT_saveFetchID       (save_fid),
        .OUT_saveOffs          (save_offs),
        .OUT_forwardIdx        (fwd),
        .OUT_stall             (stall),
        .OUT_busy              (busy)
`ifdef RET_REC_WATCHDOG_EN
        ,
        .OUT_wdError           (wd_err)
`endif
    );

`ifndef RET_REC_WATCHDOG_EN
    assign wd_err = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_defaults();
        rst           = 1'b0;
        mispr_valid   = 1'b0;
        mispr_fid     = 4'd0;
        mispr_offs    = 3'd0;
        mispr_is_fb   = 1'b0;
        ret_upd_valid = 1'b0;
        ret_upd_idx   = 3'd0;
        ret_upd_addr  = 31'd0;
        com_fid       = 4'd0;
        q_empty       = 1'b1;
        q_full        = 1'b0;
        q_top_fid     = 4'd0;
        q_top_offs    = 3'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        set_defaults();
    endtask

    task automatic set_top(input logic [3:0] fid, input logic [2:0] offs);
        q_empty    = 1'b0;
        q_top_fid  = fid;
        q_top_offs = offs;
    endtask

    task automatic mispr(input logic [3:0] fid, input logic [2:0] offs, input logic [3:0] base,
                         input logic fb, input logic upd, input logic [2:0] idx,
                         input logic [30:0] addr, input logic empty,
                         input logic [3:0] tfid, input logic [2:0] toffs);
        mispr_valid   = 1'b1;
        mispr_fid     = fid;
        mispr_offs    = offs;
        com_fid       = base;
        mispr_is_fb   = fb;
        ret_upd_valid = upd;
        ret_upd_idx   = idx;
        ret_upd_addr  = addr;
        q_empty       = empty;
        q_top_fid     = tfid;
        q_top_offs    = toffs;
    endtask

    task automatic exp_c(input string tag, input logic [4:0] fl, input logic wd);
        exp_t e;
        e       = '0;
        e.flags = fl;
        e.wd    = wd;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic exp_s(input string tag, input logic [4:0] fl, input logic [2:0] idx,
                         input logic [30:0] addr, input logic [3:0] fid, input logic [2:0] offs);
        exp_t e;
        e          = '0;
        e.flags    = fl;
        e.has_save = 1'b1;
        e.idx      = idx;
        e.addr     = addr;
        e.fid      = fid;
        e.offs     = offs;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Scoreboard: compare the cycle's outputs against the queued expectation.
    always @(negedge clk) begin : monitor
        exp_t  e;
        string t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq({t, ".flags"}, 32'({pop, save_wr, stall, busy, fwd}), 32'(e.flags));
            if (e.has_save) begin
                check_eq({t, ".idx"},  32'(save_idx),  32'(e.idx));
                check_eq({t, ".addr"}, 32'(save_addr), 32'(e.addr));
                check_eq({t, ".fid"},  32'(save_fid),  32'(e.fid));
                check_eq({t, ".offs"}, 32'(save_offs), 32'(e.offs));
            end
`ifdef RET_REC_WATCHDOG_EN
            check_eq({t, ".wd"}, 32'(wd_err), 32'(e.wd));
`endif
        end
    end

    initial begin
        set_defaults();
        rst = 1'b1;
        tick(); rst = 1'b1; exp_c("reset0", F_NONE, 1'b0);
        tick(); rst = 1'b1; exp_c("reset1", F_NONE, 1'b0);

        // Mispredict with empty queue and no save: stays idle, forward pulse only
        tick(); mispr(4'd2, 3'd0, 4'd0, 1'b0, 1'b0, 3'd0, 31'd0, 1'b1, 4'd0, 3'd0);
        exp_c("s1_mispr", F_NONE, 1'b0);
        tick(); exp_c("s1_fwd", F_FWD, 1'b0);
        tick(); exp_c("s1_idle", F_NONE, 1'b0);

        // recBase=0 recID=3 recOffs=2: tops 5,4,3/3 pop, 3/1 stops
        tick(); mispr(4'd3, 3'd2, 4'd0, 1'b0, 1'b0, 3'd0, 31'd0, 1'b0, 4'd5, 3'd3);
        exp_c("s2_mispr", F_NONE, 1'b0);
        tick(); set_top(4'd5, 3'd3); exp_c("s2_pop5", F_POP_FWD, 1'b0);
        tick(); set_top(4'd4, 3'd3); exp_c("s2_pop4", F_POP, 1'b0);
        tick(); set_top(4'd3, 3'd3); exp_c("s2_pop3", F_POP, 1'b0);
        tick(); set_top(4'd3, 3'd1); exp_c("s2_exit", F_EXIT, 1'b0);
        tick(); exp_c("s2_idle", F_NONE, 1'b0);

        // Wrap: base 14, recID 15, overwOwn=1
        tick(); mispr(4'd15, 3'd4, 4'd14, 1'b1, 1'b0, 3'd0, 31'd0, 1'b0, 4'd1, 3'd0);
        exp_c("s3_mispr", F_NONE, 1'b0);
        tick(); set_top(4'd1, 3'd0); exp_c("s3_wrap_pop", F_POP_FWD, 1'b0);
        tick(); set_top(4'd15, 3'd4); exp_c("s3_eq_own", F_POP, 1'b0);
        tick(); set_top(4'd14, 3'd7); exp_c("s3_stop", F_EXIT, 1'b0);
        tick(); exp_c("s3_idle", F_NONE, 1'b0);
        // Same setup, overwOwn=0: equal offset stops
        tick(); mispr(4'd15, 3'd4, 4'd14, 1'b0, 1'b0, 3'd0, 31'd0, 1'b0, 4'd15, 3'd4);
        exp_c("s3b_mispr", F_NONE, 1'b0);
        tick(); set_top(4'd15, 3'd4); exp_c("s3b_eq_noown", F_EXIT_FWD, 1'b0);
        tick(); exp_c("s3b_idle", F_NONE, 1'b0);

        // Save with index/address wrap, empty queue
        tick(); mispr(4'd9, 3'd5, 4'd2, 1'b1, 1'b1, 3'd7, 31'h7FFF_FFFF, 1'b1, 4'd0, 3'd0);
        exp_c("s4_mispr", F_NONE, 1'b0);
        tick(); exp_c("s4_exit", F_HOLD_FWD, 1'b0);
        tick(); exp_s("s4_save", F_SAVE_WR, 3'd0, 31'd0, 4'd9, 3'd5);
        tick(); exp_c("s4_idle", F_NONE, 1'b0);
        // One pop then a save dropped on full queue
        tick(); mispr(4'd4, 3'd1, 4'd0, 1'b1, 1'b1, 3'd2, 31'h1234, 1'b0, 4'd6, 3'd0);
        exp_c("s4b_mispr", F_NONE, 1'b0);
        tick(); set_top(4'd6, 3'd0); exp_c("s4b_pop", F_POP_FWD, 1'b0);
        tick(); exp_c("s4b_exit", F_HOLD, 1'b0);
        tick(); q_full = 1'b1; exp_s("s4b_save_full", F_HOLD, 3'd3, 31'h1235, 4'd4, 3'd1);
        tick(); exp_c("s4b_idle", F_NONE, 1'b0);

        // Second mispredict mid-walk discards pending save and restarts
        tick(); mispr(4'd5, 3'd0, 4'd0, 1'b1, 1'b1, 3'd1, 31'd10, 1'b0, 4'd7, 3'd0);
        exp_c("s5_mispr", F_NONE, 1'b0);
        tick(); set_top(4'd7, 3'd0); exp_c("s5_pop", F_POP_FWD, 1'b0);
        tick(); mispr(4'd8, 3'd3, 4'd6, 1'b0, 1'b0, 3'd0, 31'd0, 1'b0, 4'd7, 3'd0);
        exp_c("s5_remispr", F_HOLD, 1'b0);
        tick(); set_top(4'd9, 3'd0); exp_c("s5_pop_new", F_POP_FWD, 1'b0);
        tick(); set_top(4'd8, 3'd3); exp_c("s5_exit", F_EXIT, 1'b0);
        tick(); exp_c("s5_idle_nosave", F_NONE, 1'b0);

        // Reset in the middle of a walk
        tick(); mispr(4'd3, 3'd0, 4'd0, 1'b0, 1'b0, 3'd0, 31'd0, 1'b0, 4'd5, 3'd0);
        exp_c("s6_mispr", F_NONE, 1'b0);
        tick(); set_top(4'd5, 3'd0); exp_c("s6_pop", F_POP_FWD, 1'b0);
        tick(); set_top(4'd5, 3'd0); rst = 1'b1; exp_c("s6_rst", F_NONE, 1'b0);
        tick(); set_top(4'd5, 3'd0); exp_c("s6_after", F_NONE, 1'b0);

`ifdef RET_REC_WATCHDOG_EN
        // Endless walk trips the watchdog after RQSIZE+1 pops
        tick(); mispr(4'd0, 3'd0, 4'd0, 1'b0, 1'b0, 3'd0, 31'd0, 1'b0, 4'd1, 3'd0);
        exp_c("wd_mispr", F_NONE, 1'b0);
        for (int k = 1; k <= RQSIZE + 1; k++) begin
            tick(); set_top(4'd1, 3'd0);
            exp_c("wd_walk", (k == 1) ? F_POP_FWD : F_POP, 1'b0);
        end
        tick(); set_top(4'd1, 3'd0); exp_c("wd_trip", F_HOLD, 1'b0);
        tick(); set_top(4'd1, 3'd0); exp_c("wd_err", F_NONE, 1'b1);
        tick(); exp_c("wd_sticky", F_NONE, 1'b1);
`endif

        tick();
        tick();
        @(negedge clk);
        #1;
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
